layer_vec_serializer: RTL

//  Consumer stage directly downstream of a layer ringbuffer.
//  - Captures one buffered layer-input vector (ninputs field elements) plus its prover-side instance id.
//  - Streams the vector to the prover layer one word per handshake, over a valid/ready interface.
//  - Gives the prover a serial read of v_in_pl, so it does not need ninputs-wide muxing.

---
 rtl/layer_vec_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/layer_vec_serializer.sv
// Purpose : capture one layer-input vector plus its instance id and stream it word by word.
// Latency : first out_valid 1 cycle after load; then one word per handshake.
// Backpres: out_ready low holds every output stable; valid is never retracted mid-vector.
//
// Ports:
//   clk, rstb          clock; asynchronous active-low reset
//   load, v_in, id_in  capture request from the ringbuffer (vector + prover instance id)
//   out_valid/out_ready/out_data/out_idx/out_last/out_id  word stream to the prover layer
//   busy, done         streaming status; done pulses the cycle after the final handshake
//   overrun            sticky "load dropped while streaming" flag
// Optional feature macro: LAYER_VEC_SER_OVERRUN_EN (undefined -> overrun tied 0, drops silent).
module layer_vec_serializer #(
  parameter int ninputs   = 8,
  parameter int layer_num = 0,
  parameter int F_NBITS   = 32,
  localparam int IW       = (ninputs > 1) ? $clog2(ninputs) : 1
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             load,
  input  logic [ninputs-1:0][F_NBITS-1:0]  v_in,
  input  logic [31:0]                      id_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [F_NBITS-1:0]               out_data,
  output logic [IW-1:0]                    out_idx,
  output logic                             out_last,
  output logic [31:0]                      out_id,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);

  if (ninputs < 1) begin : g_bad_cfg
    $error("layer_vec_serializer layer %0d: ninputs must be >= 1", layer_num);
  end

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(ninputs - 1);

  state_t                          state;
  logic [ninputs-1:0][F_NBITS-1:0] shadow;
  logic                            fin_hs;

  // Final handshake of the current vector; a load arriving here is a legal back-to-back reload.
  assign out_last = out_valid && (out_idx == LAST_IDX);
  assign fin_hs   = out_last && out_ready;

  if (ninputs == 1) begin : g_mux1
    assign out_data = shadow[0];
  end else begin : g_muxn
    assign out_data = shadow[out_idx];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      shadow    <= '0;
      out_idx   <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shadow    <= v_in;
            out_id    <= id_in;
            out_idx   <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (fin_hs) begin
            done <= 1'b1;
            if (load) begin
              // Reload in place: stay in STREAM so out_valid never drops between vectors.
              shadow  <= v_in;
              out_id  <= id_in;
              out_idx <= '0;
            end else begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else if (out_ready) begin
            out_idx <= out_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAYER_VEC_SER_OVERRUN_EN
  logic drop;
  logic overrun_q;

  // A load while streaming is only accepted on the final handshake; anything else is lost.
  assign drop    = load && (state == STREAM) && !fin_hs;
  assign overrun = overrun_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rstb) begin
      assert (!drop)
        else $error("layer_vec_serializer layer %0d: load dropped while streaming", layer_num);
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule
